cpu_pin_host_loader: RTL and testbench

// - Host-side driver for the 8-bit CPU tile pin interface. Takes bytes from a

---
 rtl/cpu_pin_host_loader.sv | 219 +++++++++++++++++++++
 tb/tb_cpu_pin_host_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_pin_host_loader.sv
// cpu_pin_host_loader
// Host-side driver for the 8-bit CPU tile pin interface. Bytes arrive on a
// valid/ready stream, are buffered in a small FIFO, and are presented one at
// a time on the tile's dedicated inputs using a 4-phase STB/ACK handshake.
// The tile's dedicated-output byte is captured at each ACK and returned as a
// one-cycle response pulse.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   s_valid/s_data      input byte stream, s_ready = FIFO not full
//   pin_ui              byte presented to tile ui_in (held until next pop)
//   pin_uio_drv         tile uio_in; bit0 = STB, other bits 0
//   pin_uio_in          tile uio_out; bit1 = ACK (asynchronous)
//   pin_uo              tile uo_out, captured when synchronized ACK rises
//   m_valid/m_data      response pulse and captured byte
//   busy                handshake in progress or bytes buffered
//   fifo_count          bytes buffered
//   timeout_err         sticky handshake timeout flag
//   clr_err             synchronous clear of the sticky error flags
//   echo_err            (only with LOADER_ECHO_CHECK_EN) sticky flag set when
//                       the captured byte differs from the byte presented
//
// Optional feature macro: LOADER_ECHO_CHECK_EN
module cpu_pin_host_loader #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  input  logic [7:0]                    s_data,
  output logic                          s_ready,
  output logic [7:0]                    pin_ui,
  output logic [7:0]                    pin_uio_drv,
  input  logic [7:0]                    pin_uio_in,
  input  logic [7:0]                    pin_uo,
  output logic                          m_valid,
  output logic [7:0]                    m_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          timeout_err,
`ifdef LOADER_ECHO_CHECK_EN
  output logic                          echo_err,
`endif
  input  logic                          clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_RELEASE} state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic                   stb_q, stb_d;
  logic [7:0]             pin_ui_q, pin_ui_d;
  logic [7:0]             m_data_q, m_data_d;
  logic                   m_valid_q, m_valid_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [7:0]             mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   push, pop, timeout_hit, ack_s;
  logic                   unused_pins;
`ifdef LOADER_ECHO_CHECK_EN
  logic                   echo_err_q, echo_err_d, echo_hit;
`endif

  assign ack_s       = sync_q[SYNC_STAGES-1];
  assign s_ready     = (count_q != FULL);
  assign push        = s_valid && s_ready;
  assign pin_ui      = pin_ui_q;
  assign pin_uio_drv = {7'b0, stb_q};
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign busy        = (state_q != ST_IDLE) || (count_q != '0);
  assign fifo_count  = count_q;
  assign timeout_err = timeout_err_q;
  assign unused_pins = ^{pin_uio_in[7:2], pin_uio_in[0]};
`ifdef LOADER_ECHO_CHECK_EN
  assign echo_err    = echo_err_q;
`endif

  // Next-state logic for the handshake FSM, FIFO and sticky flags.
  // The timeout check has priority in every waiting state so a stuck tile
  // always releases STB and drops the current byte.
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    stb_d       = stb_q;
    pin_ui_d    = pin_ui_q;
    m_data_d    = m_data_q;
    m_valid_d   = 1'b0;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    sync_d      = {sync_q[SYNC_STAGES-2:0], pin_uio_in[1]};
`ifdef LOADER_ECHO_CHECK_EN
    echo_hit    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        tcnt_d = '0;
        stb_d  = 1'b0;
        if (count_q != '0) begin
          pop      = 1'b1;
          pin_ui_d = mem_q[rd_ptr_q];
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tcnt_q == TMAX) begin
          timeout_hit = 1'b1;
        end else if (ack_s) begin
          tcnt_d = tcnt_q + 1'b1;
        end else begin
          state_d = ST_STROBE;
          stb_d   = 1'b1;
          tcnt_d  = '0;
        end
      end
      ST_STROBE: begin
        if (tcnt_q == TMAX) begin
          timeout_hit = 1'b1;
        end else if (ack_s) begin
          m_data_d  = pin_uo;
          m_valid_d = 1'b1;
          stb_d     = 1'b0;
          state_d   = ST_RELEASE;
          tcnt_d    = '0;
`ifdef LOADER_ECHO_CHECK_EN
          echo_hit  = (pin_uo != pin_ui_q);
`endif
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (tcnt_q == TMAX) begin
          timeout_hit = 1'b1;
        end else if (!ack_s) begin
          state_d = ST_IDLE;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout_hit) begin
      state_d = ST_IDLE;
      stb_d   = 1'b0;
      tcnt_d  = '0;
    end

    // Set beats clear when both happen in the same cycle.
    timeout_err_d = timeout_hit ? 1'b1 : (clr_err ? 1'b0 : timeout_err_q);
`ifdef LOADER_ECHO_CHECK_EN
    echo_err_d    = echo_hit ? 1'b1 : (clr_err ? 1'b0 : echo_err_q);
`endif

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = s_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // All state registers; reset drops STB and empties the FIFO immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tcnt_q        <= '0;
      stb_q         <= 1'b0;
      pin_ui_q      <= '0;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      sync_q        <= '0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
`ifdef LOADER_ECHO_CHECK_EN
      echo_err_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      stb_q         <= stb_d;
      pin_ui_q      <= pin_ui_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      timeout_err_q <= timeout_err_d;
      sync_q        <= sync_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
`ifdef LOADER_ECHO_CHECK_EN
      echo_err_q    <= echo_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_pin_host_loader.sv
// Directed testbench for cpu_pin_host_loader. A simple tile responder raises
// ACK one cycle after it sees STB and returns pin_ui XOR a selectable mask.
module tb_cpu_pin_host_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [7:0] pin_ui;
  logic [7:0] pin_uio_drv;
  logic [7:0] pin_uio_in;
  logic [7:0] pin_uo;
  logic       m_valid;
  logic [7:0] m_data;
  logic       busy;
  logic [2:0] fifo_count;
  logic       timeout_err;
  logic       clr_err;
`ifdef LOADER_ECHO_CHECK_EN
  logic       echo_err;
`endif

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic       resp_en;
  logic [7:0] uo_xor;
  logic       ack_r;

  logic [7:0] rsp_q[$];
  int         rsp_t[$];
  logic       prev_mv;
  int         consec = 0;

  cpu_pin_host_loader dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .pin_ui      (pin_ui),
    .pin_uio_drv (pin_uio_drv),
    .pin_uio_in  (pin_uio_in),
    .pin_uo      (pin_uo),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .timeout_err (timeout_err),
`ifdef LOADER_ECHO_CHECK_EN
    .echo_err    (echo_err),
`endif
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Tile responder: ACK follows STB with one cycle of latency.
  always @(posedge clk or posedge rst) begin
    if (rst) ack_r <= 1'b0;
    else     ack_r <= resp_en & pin_uio_drv[0];
  end
  assign pin_uio_in = {6'b0, ack_r, 1'b0};
  assign pin_uo     = pin_ui ^ uo_xor;

  // Response monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_mv = 1'b0;
    end else begin
      if (m_valid) begin
        rsp_q.push_back(m_data);
        rsp_t.push_back(cycle);
        if (prev_mv) consec++;
      end
      prev_mv = m_valid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_stb(output int n);
    n = 0;
    while (!pin_uio_drv[0] && n < 20) begin tick(); n++; end
  endtask

  task automatic wait_done(input int nrsp);
    int n = 0;
    while ((rsp_q.size() < nrsp || busy) && n < 400) begin tick(); n++; end
    checks++;
    if (busy !== 1'b0 || rsp_q.size() != nrsp) begin
      errors++;
      $display("[TB] FAIL wait_done busy=%0b rsp=%0d want 0/%0d", busy, rsp_q.size(), nrsp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; clr_err = 1'b0; resp_en = 1'b0; uo_xor = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pin_uio_drv !== 8'h00) begin errors++; $display("[TB] FAIL rst_drv got %0h want 0", pin_uio_drv); end
    checks++; if (pin_ui !== 8'h00) begin errors++; $display("[TB] FAIL rst_ui got %0h want 0", pin_ui); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL rst_count got %0d want 0", fifo_count); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got %0b want 1", s_ready); end
    checks++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_m got %0b/%0h want 0/0", m_valid, m_data); end
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_flags got %0b/%0b want 0/0", timeout_err, busy); end
    @(negedge clk) rst = 1'b0;
    tick();
  endtask

  task automatic test_single_byte;
    int n;
    rsp_q.delete(); rsp_t.delete();
    resp_en = 1'b1; uo_xor = 8'hFF;
    push_byte(8'hA5);
    checks++; if (fifo_count !== 3'd1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL single_push count=%0d busy=%0b want 1/1", fifo_count, busy); end
    tick();
    checks++; if (pin_ui !== 8'hA5 || pin_uio_drv !== 8'h00 || fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL single_setup ui=%0h drv=%0h cnt=%0d want a5/0/0", pin_ui, pin_uio_drv, fifo_count); end
    tick();
    checks++; if (pin_uio_drv !== 8'h01) begin errors++; $display("[TB] FAIL single_strobe drv=%0h want 1", pin_uio_drv); end
    n = 0;
    while (!m_valid && n < 20) begin tick(); n++; end
    checks++; if (m_valid !== 1'b1 || n != 4) begin errors++; $display("[TB] FAIL single_ack_lat mv=%0b cycles=%0d want 1/4", m_valid, n); end
    checks++; if (m_data !== 8'h5A || pin_uio_drv !== 8'h00) begin errors++; $display("[TB] FAIL single_data got %0h drv=%0h want 5a/0", m_data, pin_uio_drv); end
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse got %0b want 0", m_valid); end
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    checks++; if (busy !== 1'b0 || n != 3) begin errors++; $display("[TB] FAIL single_release busy=%0b cycles=%0d want 0/3", busy, n); end
    checks++; if (pin_ui !== 8'hA5 || rsp_q.size() != 1) begin errors++; $display("[TB] FAIL single_hold ui=%0h rsp=%0d want a5/1", pin_ui, rsp_q.size()); end
  endtask

  task automatic test_full_fifo;
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] exp  [5] = '{8'h10, 8'h11, 8'h22, 8'h33, 8'h44};
    int n;
    rsp_q.delete(); rsp_t.delete(); consec = 0;
    resp_en = 1'b0; uo_xor = 8'h00;
    push_byte(8'h10);
    wait_stb(n);
    checks++; if (pin_uio_drv !== 8'h01) begin errors++; $display("[TB] FAIL full_stall drv=%0h want 1", pin_uio_drv); end
    for (int i = 0; i < 4; i++) push_byte(vals[i]);
    checks++; if (fifo_count !== 3'd4 || s_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_level cnt=%0d ready=%0b want 4/0", fifo_count, s_ready); end
    s_valid = 1'b1; s_data = 8'h55;
    tick();
    s_valid = 1'b0;
    checks++; if (fifo_count !== 3'd4 || rsp_q.size() != 0) begin errors++; $display("[TB] FAIL full_reject cnt=%0d rsp=%0d want 4/0", fifo_count, rsp_q.size()); end
    resp_en = 1'b1;
    wait_done(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= rsp_q.size() || rsp_q[i] !== exp[i]) begin
        errors++;
        $display("[TB] FAIL full_order[%0d] got %0h want %0h", i, (i < rsp_q.size()) ? rsp_q[i] : 8'hxx, exp[i]);
      end
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (i >= rsp_t.size() || rsp_t[i] - rsp_t[i-1] != 10) begin
        errors++;
        $display("[TB] FAIL b2b_period[%0d] got %0d want 10", i, (i < rsp_t.size()) ? rsp_t[i] - rsp_t[i-1] : -1);
      end
    end
    checks++; if (consec != 0) begin errors++; $display("[TB] FAIL mvalid_consec got %0d want 0", consec); end
  endtask

  task automatic test_push_pop;
    rsp_q.delete(); rsp_t.delete();
    resp_en = 1'b1; uo_xor = 8'h00;
    s_valid = 1'b1; s_data = 8'h66;
    tick();
    checks++; if (fifo_count !== 3'd1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL pp_first cnt=%0d busy=%0b want 1/1", fifo_count, busy); end
    s_data = 8'h67;
    tick();
    s_valid = 1'b0;
    checks++; if (fifo_count !== 3'd1 || pin_ui !== 8'h66) begin errors++; $display("[TB] FAIL pp_same cnt=%0d ui=%0h want 1/66", fifo_count, pin_ui); end
    wait_done(2);
    checks++; if (rsp_q.size() != 2 || rsp_q[0] !== 8'h66 || rsp_q[1] !== 8'h67) begin errors++; $display("[TB] FAIL pp_rsp got %0d entries want 66,67", rsp_q.size()); end
  endtask

  task automatic test_reset_mid_strobe;
    int n;
    resp_en = 1'b0;
    push_byte(8'h99);
    push_byte(8'h9A);
    wait_stb(n);
    checks++; if (pin_uio_drv !== 8'h01 || fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL mid_pre drv=%0h cnt=%0d want 1/1", pin_uio_drv, fifo_count); end
    rst = 1'b1;
    #1;
    checks++; if (pin_uio_drv !== 8'h00 || fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL mid_rst drv=%0h cnt=%0d want 0/0", pin_uio_drv, fifo_count); end
    checks++; if (pin_ui !== 8'h00 || m_data !== 8'h00 || m_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_out ui=%0h md=%0h mv=%0b want 0", pin_ui, m_data, m_valid); end
    checks++; if (busy !== 1'b0 || s_ready !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_flags busy=%0b rdy=%0b to=%0b want 0/1/0", busy, s_ready, timeout_err); end
    @(negedge clk) rst = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_after busy=%0b want 0", busy); end
  endtask

  task automatic test_timeout;
    int n;
    rsp_q.delete(); rsp_t.delete();
    resp_en = 1'b0;
    push_byte(8'h77);
    wait_stb(n);
    repeat (200) tick();
    checks++; if (timeout_err !== 1'b0 || pin_uio_drv !== 8'h01) begin errors++; $display("[TB] FAIL to_early err=%0b drv=%0h want 0/1", timeout_err, pin_uio_drv); end
    n = 200;
    while (!timeout_err && n < 400) begin tick(); n++; end
    checks++; if (timeout_err !== 1'b1 || n < 255 || n > 257) begin errors++; $display("[TB] FAIL to_fire err=%0b cycles=%0d want 1/255..257", timeout_err, n); end
    checks++; if (pin_uio_drv !== 8'h00 || rsp_q.size() != 0) begin errors++; $display("[TB] FAIL to_drop drv=%0h rsp=%0d want 0/0", pin_uio_drv, rsp_q.size()); end
    repeat (3) tick();
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL to_sticky err=%0b busy=%0b want 1/0", timeout_err, busy); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL to_clear got %0b want 0", timeout_err); end
  endtask

`ifdef LOADER_ECHO_CHECK_EN
  task automatic test_echo;
    rsp_q.delete(); rsp_t.delete();
    resp_en = 1'b1; uo_xor = 8'h01;
    push_byte(8'h3C);
    wait_done(1);
    checks++; if (echo_err !== 1'b1 || m_data !== 8'h3D) begin errors++; $display("[TB] FAIL echo_bad err=%0b md=%0h want 1/3d", echo_err, m_data); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if (echo_err !== 1'b0) begin errors++; $display("[TB] FAIL echo_clear got %0b want 0", echo_err); end
    uo_xor = 8'h00;
    push_byte(8'h3C);
    wait_done(2);
    checks++; if (echo_err !== 1'b0 || m_data !== 8'h3C) begin errors++; $display("[TB] FAIL echo_good err=%0b md=%0h want 0/3c", echo_err, m_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_full_fifo();
    test_push_pop();
    test_reset_mid_strobe();
    test_timeout();
`ifdef LOADER_ECHO_CHECK_EN
    test_echo();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
